uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the team's UART link. It decodes the frame our transmitter sends: start bit (0), 8 data bits LSB first, parity bit equal to the XOR of the data bits, and stop bit (1). The line is oversampled using a tick enable from the baud generator. Each received byte is presented on a parallel bus with a one-cycle done strobe plus parity and framing status.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit period; must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-`clk` enable pulse at `OVERSAMPLE` × baud, from the baud generator.
- `rx` in 1: asynchronous serial line; idles high.
- `data_out` out `DATA_BITS`: last received byte; holds until the next frame completes.
- `rx_done` out 1: one-`clk` pulse when a frame completes.
- `parity_err` out 1: parity status of the last frame; valid from `rx_done`, then held.
- `frame_err` out 1: stop-bit status of the last frame; valid from `rx_done`, then held.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized value `rx_s` is used.
- Counters:
  - Tick counter: width `$clog2(OVERSAMPLE)`.
  - Bit counter: width `$clog2(DATA_BITS)`.
  - Both counters advance only on `clk` edges where `tick`=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - On a tick with `rx_s`=0 and `armed`=1: clear the tick counter and go to START.
  - `armed` sets on any tick with `rx_s`=1. It clears on a framing error.
  - A line held low after a bad frame therefore never starts a new frame.
- **START**
  - Count ticks. On the tick where the count reaches `OVERSAMPLE/2 - 1` (mid start bit), sample `rx_s`.
  - If `rx_s`=0: clear the tick counter, clear the bit counter, go to DATA.
  - If `rx_s`=1 (glitch): return to IDLE with no strobe and no output change.
- **DATA**
  - On every tick where the count reaches `OVERSAMPLE - 1`: sample `rx_s` and shift it into the MSB of the shift register (right-shift, so the LSB-first bits land in order).
  - After `DATA_BITS` samples, go to PARITY.
- **PARITY** (present only with the macro)
  - After `OVERSAMPLE` ticks, sample the parity bit `p`.
  - Store `perr = p ^ (^shift)`; 1 means mismatch.
  - Go to STOP.
- **STOP**
  - After `OVERSAMPLE` ticks, sample `rx_s`.
  - Load `data_out` with the shift register and `parity_err` with `perr`.
  - Load `frame_err` with the inverse of the sampled stop bit.
  - Pulse `rx_done` and return to IDLE.
  - If `frame_err`=1, also clear `armed`.
- A byte with a parity or framing error is still delivered on `data_out`. The flags qualify it.

## Timing
- Reset values:
  - Outputs: `data_out`=0, `rx_done`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - Internal: state IDLE, counters 0, `armed`=1, synchronizer flops 1.
- `rx_done` is registered. It rises on the `clk` edge after the mid-stop-bit sampling tick and is high for exactly one `clk`.
- `data_out` and both error flags update on the same edge that raises `rx_done`.
- Detection latency:
  - Start is detected 2 `clk` (synchronizer) plus up to 1 tick after the falling edge.
  - Samples are taken at bit centre ±1 tick.
- End-to-end: the stop bit is sampled at about 10.5 bit periods after the start edge with parity, 9.5 without.
- Back-to-back frames: the FSM is back in IDLE at mid stop bit, so a start bit immediately following the stop bit is caught.
- `rst` asserted mid-frame:
  - Aborts the frame on the next edge; no `rx_done`.
  - `data_out` and the flags return to 0.
- `tick` low: the FSM and counters hold; there is no timeout.
- `rst` and `tick` on the same edge: `rst` wins.

## Configuration
- `UART_RX_PARITY_EN`, defined (default build, matching our transmitter):
  - Frame is start + `DATA_BITS` + parity + stop.
  - PARITY state is used and `parity_err` is checked.
- Not defined:
  - PARITY state is removed; DATA goes directly to STOP.
  - Frame is start + `DATA_BITS` + stop.
  - `parity_err` is tied to 0.

## Test plan
- **Good frame.** Reset, then send 0xA5 with parity 0 and stop 1, 16 ticks per bit. Required: one `rx_done` pulse, `data_out`=0xA5, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- **Start glitch.** Drive `rx` low for 4 ticks, then high. Required: no `rx_done`, state returns to IDLE, `data_out` unchanged.
- **Parity error.** Send 0x01 with parity bit 0. Required: `data_out`=0x01, `parity_err`=1, `frame_err`=0.
- **Framing error and recovery.**
  - Send 0x3C with stop bit 0, then hold `rx` low for 40 bit periods. Required: `frame_err`=1 and no further `rx_done`.
  - Release the line high, then send 0x55. Required: `data_out`=0x55, `frame_err`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap. Required: two `rx_done` pulses, values 0x00 then 0xFF, no errors.
- **Reset mid-frame.** Assert `rst` for 1 `clk` during data bit 4 of a 0x81 frame. Required: no `rx_done`, all outputs 0. The next 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled serial receiver, start + DATA_BITS (+ parity) + stop.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 armed;
`ifdef UART_RX_PARITY_EN
    logic                 perr;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            armed     <= 1'b1;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;
            if (tick) begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            tick_cnt <= '0;
                            state    <= S_START;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == T_MID) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= S_DATA;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == T_END) begin
                            tick_cnt <= '0;
                            shift    <= {rx_s, shift[DATA_BITS-1:1]};
                            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_cnt == T_END) begin
                            tick_cnt <= '0;
                            perr     <= rx_s ^ (^shift);
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (tick_cnt == T_END) begin
                            tick_cnt  <= '0;
                            data_out  <= shift;
                            frame_err <= ~rx_s;
                            rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= perr;
`endif
                            // a line stuck low must not retrigger a frame
                            if (!rx_s) armed <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, corner sequences and random frames for uart_rx.
// Expected results come from a frame-level scoreboard, not from the RTL.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int TP = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx         (rx),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    logic [7:0] cap_data [128];
    logic       cap_perr [128];
    logic       cap_ferr [128];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (TP - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done) begin
            cap_data[done_cnt] <= data_out;
            cap_perr[done_cnt] <= parity_err;
            cap_ferr[done_cnt] <= frame_err;
            done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c++;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(n * OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PEN) send_bit(p);
        send_bit(s);
    endtask

    task automatic check_frame(input string name, input int idx,
                               input logic [7:0] ed, input logic ep,
                               input logic ef);
        check({name, " data"}, 32'(cap_data[idx]), 32'(ed));
        check({name, " perr"}, 32'(cap_perr[idx]), 32'(ep));
        check({name, " ferr"}, 32'(cap_ferr[idx]), 32'(ef));
    endtask

    vec_t vecs [6];

    initial begin
        int d0;
        logic [7:0] hold;
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         ones;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, PEN,  1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b0, 8'hC3, PEN,  1'b1};
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset rx_done", 32'(rx_done), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle_bits(2);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            send_frame(vecs[i].data, (^vecs[i].data) ^ vecs[i].pflip,
                       vecs[i].stop);
            idle_bits(2);
            check($sformatf("vec%0d done count", i), 32'(done_cnt),
                  32'(d0 + 1));
            check_frame($sformatf("vec%0d", i), d0, vecs[i].exp_data,
                        vecs[i].exp_perr, vecs[i].exp_ferr);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
        end

        // start glitch shorter than half a bit
        d0 = done_cnt;
        hold = data_out;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        check("glitch busy during", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_ticks(2 * OS);
        @(negedge clk);
        check("glitch no done", 32'(done_cnt), 32'(d0));
        check("glitch busy after", 32'(busy), 32'h0);
        check("glitch data_out held", 32'(data_out), 32'(hold));

        // framing error, line held low, then recovery
        d0 = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(40 * OS);
        @(negedge clk);
        check("stuck done count", 32'(done_cnt), 32'(d0 + 1));
        check_frame("stuck", d0, 8'h3C, 1'b0, 1'b1);
        check("stuck busy", 32'(busy), 32'h0);
        idle_bits(2);
        d0 = done_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(2);
        check("recover done count", 32'(done_cnt), 32'(d0 + 1));
        check_frame("recover", d0, 8'h55, 1'b0, 1'b0);

        // back-to-back frames
        d0 = done_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(2);
        check("b2b done count", 32'(done_cnt), 32'(d0 + 2));
        check_frame("b2b first", d0, 8'h00, 1'b0, 1'b0);
        check_frame("b2b second", d0 + 1, 8'hFF, 1'b0, 1'b0);

        // reset during data bit 4 of 0x81
        d0 = done_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(OS / 2);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst data_out", 32'(data_out), 32'h0);
        check("rst rx_done", 32'(rx_done), 32'h0);
        check("rst parity_err", 32'(parity_err), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        idle_bits(2);
        check("rst no done", 32'(done_cnt), 32'(d0));
        send_frame(8'h81, 1'b0, 1'b1);
        idle_bits(2);
        check("rst next done count", 32'(done_cnt), 32'(d0 + 1));
        check_frame("rst next", d0, 8'h81, 1'b0, 1'b0);

        // random frames against the frame-level model
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            ones = 0;
            for (int b = 0; b < 8; b++) ones += int'(rd[b]);
            d0 = done_cnt;
            send_frame(rd, rp, rs);
            idle_bits(2);
            check($sformatf("rand%0d done count", n), 32'(done_cnt),
                  32'(d0 + 1));
            check_frame($sformatf("rand%0d", n), d0, rd,
                        PEN && (((ones + int'(rp)) % 2) == 1), !rs);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
